// File: rtl/branch_predictor_btb_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_btb_if
//
// Bundles the fetch-side lookup signals and the resolve-side update signals of
// the branch target buffer. The core (or a bench) uses the master modport and
// drives the lookup request and the update; the predictor uses the slave
// modport and returns the prediction.
//
// Lookup  : if_valid, if_pc, stall            (master -> slave)
// Predict : pred_taken, pred_target,
//           pred_idx, pred_ghr                (slave -> master)
// Update  : upd_valid, upd_pc, upd_idx, upd_ghr,
//           upd_taken, upd_target,
//           upd_mispredict                    (master -> slave)
// -----------------------------------------------------------------------------
interface branch_predictor_btb_if #(
  parameter int ADDR_W = 64,
  parameter int IDX_W  = 4,
  parameter int GHR_W  = 4
);
  // fetch-side lookup
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic              stall;

  // prediction returned to the PC mux
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic [IDX_W-1:0]  pred_idx;
  logic [GHR_W-1:0]  pred_ghr;

  // resolution write-back from the branch-control stage
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic [IDX_W-1:0]  upd_idx;
  logic [GHR_W-1:0]  upd_ghr;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_mispredict;

  modport master (
    output if_valid, if_pc, stall,
    output upd_valid, upd_pc, upd_idx, upd_ghr, upd_taken, upd_target, upd_mispredict,
    input  pred_taken, pred_target, pred_idx, pred_ghr
  );

  modport slave (
    input  if_valid, if_pc, stall,
    input  upd_valid, upd_pc, upd_idx, upd_ghr, upd_taken, upd_target, upd_mispredict,
    output pred_taken, pred_target, pred_idx, pred_ghr
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// -----------------------------------------------------------------------------
// branch_predictor_btb
//
// Branch target buffer with per-entry saturating direction counters and an
// optional gshare (global-history XOR) indexing mode. Sits beside the fetch PC
// and gives a same-cycle taken/target prediction; resolved branches write
// back through the update side of the interface.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   reset  - asynchronous, active-low reset
//   bus    - branch_predictor_btb_if.slave
//              lookup : if_valid, if_pc, stall
//              predict: pred_taken, pred_target, pred_idx, pred_ghr
//              update : upd_valid, upd_pc, upd_idx, upd_ghr, upd_taken,
//                       upd_target, upd_mispredict
//
// Parameters:
//   ADDR_W    - PC / target width
//   ENTRIES   - table entries (power of two, >= 2)
//   TAG_W     - tag bits stored per entry
//   CTR_W     - direction counter width (>= 1)
//   PRED_MODE - 0: bimodal index, 1: gshare index
//   GHR_W     - global history bits (1..log2(ENTRIES)); unused in mode 0
// -----------------------------------------------------------------------------
module branch_predictor_btb #(
  parameter int ADDR_W    = 64,
  parameter int ENTRIES   = 16,
  parameter int TAG_W     = 8,
  parameter int CTR_W     = 2,
  parameter int PRED_MODE = 0,
  parameter int GHR_W     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  branch_predictor_btb_if.slave  bus
);

  localparam int IDX_W = $clog2(ENTRIES);

  // Counter encodings: reset to weakly not-taken, allocate as weakly taken.
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_MAX     = {CTR_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Flattened read views of the per-entry state (driven from g_entry below)
  // ---------------------------------------------------------------------------
  logic [ENTRIES-1:0] valid_vec;
  logic [TAG_W-1:0]   tag_arr    [ENTRIES];
  logic [ADDR_W-1:0]  target_arr [ENTRIES];
  logic [CTR_W-1:0]   ctr_arr    [ENTRIES];

  logic [GHR_W-1:0]   ghr_q;

  // ---------------------------------------------------------------------------
  // Combinational lookup
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_base;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;

  assign lk_base = bus.if_pc[IDX_W+1:2];
  assign lk_tag  = bus.if_pc[TAG_W+IDX_W+1:IDX_W+2];

  // ghr_q is tied to zero in bimodal mode, so the XOR collapses to the plain
  // PC index there; the cast zero-extends the history up to the index width.
  assign lk_idx  = lk_base ^ IDX_W'(ghr_q);

  assign lk_hit   = bus.if_valid && valid_vec[lk_idx] && (tag_arr[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && ctr_arr[lk_idx][CTR_W-1];

  assign bus.pred_taken  = lk_taken;
  assign bus.pred_target = lk_taken ? target_arr[lk_idx] : (bus.if_pc + ADDR_W'(4));
  assign bus.pred_idx    = lk_idx;
  assign bus.pred_ghr    = ghr_q;

  // ---------------------------------------------------------------------------
  // Update-side decode shared by all entries
  // ---------------------------------------------------------------------------
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [CTR_W-1:0] up_ctr_old;
  logic [CTR_W-1:0] up_ctr_step;

  assign up_tag     = bus.upd_pc[TAG_W+IDX_W+1:IDX_W+2];
  assign up_hit     = valid_vec[bus.upd_idx] && (tag_arr[bus.upd_idx] == up_tag);
  assign up_ctr_old = ctr_arr[bus.upd_idx];

  // Saturating step of the addressed entry's counter toward the outcome.
  always_comb begin
    up_ctr_step = up_ctr_old;
    if (bus.upd_taken) begin
      if (up_ctr_old != CTR_MAX) begin
        up_ctr_step = up_ctr_old + CTR_W'(1);
      end
    end else begin
      if (up_ctr_old != '0) begin
        up_ctr_step = up_ctr_old - CTR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Table entries: each one decodes its own write and holds its own flops.
  // Kept in flops rather than RAM because lookup is same-cycle and all valid
  // bits and counters must clear asynchronously.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic              valid_q,  valid_d;
      logic [TAG_W-1:0]  tag_q,    tag_d;
      logic [ADDR_W-1:0] target_q, target_d;
      logic [CTR_W-1:0]  ctr_q,    ctr_d;
      logic              sel;

      assign sel = bus.upd_valid && (bus.upd_idx == IDX_W'(gi));

      always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (sel) begin
          if (up_hit) begin
            // Trained entry: move the counter, refresh target on taken.
            ctr_d = up_ctr_step;
            if (bus.upd_taken) begin
              target_d = bus.upd_target;
            end
          end else if (bus.upd_taken) begin
            // Miss on a taken branch: replace whatever lives here.
            valid_d  = 1'b1;
            tag_d    = up_tag;
            target_d = bus.upd_target;
            ctr_d    = CTR_WEAK_T;
          end
          // Miss on a not-taken branch leaves the entry alone.
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          valid_q  <= 1'b0;
          tag_q    <= '0;
          target_q <= '0;
          ctr_q    <= CTR_WEAK_NT;
        end else begin
          valid_q  <= valid_d;
          tag_q    <= tag_d;
          target_q <= target_d;
          ctr_q    <= ctr_d;
        end
      end

      assign valid_vec[gi]  = valid_q;
      assign tag_arr[gi]    = tag_q;
      assign target_arr[gi] = target_q;
      assign ctr_arr[gi]    = ctr_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Global history register (gshare mode only)
  // ---------------------------------------------------------------------------
  generate
    if (PRED_MODE == 1) begin : g_ghr
      logic [GHR_W-1:0] ghr_d;

      // A mispredict rebuilds history from the snapshot carried with the
      // branch plus its real outcome, and wins over any speculative shift
      // from this cycle's fetch. Shifting by one and OR-ing in the new bit
      // also covers GHR_W == 1, where the result is just the new bit.
      always_comb begin
        ghr_d = ghr_q;
        if (bus.upd_valid && bus.upd_mispredict) begin
          ghr_d = (bus.upd_ghr << 1) | GHR_W'(bus.upd_taken);
        end else if (lk_hit && !bus.stall) begin
          ghr_d = (ghr_q << 1) | GHR_W'(lk_taken);
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ghr_q <= '0;
        end else begin
          ghr_q <= ghr_d;
        end
      end
    end else begin : g_no_ghr
      assign ghr_q = '0;
    end
  endgenerate

endmodule
